// File: rtl/aes1_stream_pkg.sv
// Shared types and constants for the AES stream controller.
// Holds the FSM state enum and the block/word geometry.
package aes1_stream_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/aes1_stream_if.sv
// Valid/ready word stream bundle used around the AES stream controller.
// Signals: data, valid (producer side) and ready (consumer side).
interface aes1_stream_if
  import aes1_stream_pkg::*;
#(
  parameter int W = WORD_W
);

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/aes1_stream_ctrl.sv
// Packs four 32-bit words into a 128-bit AES block, starts the core,
// waits (with timeout) for the result and streams it back as 4 words.
// Ports: clk_i/rst_ni, flush_i, s_* input stream, core_* AES core side,
// m_* output stream, busy_o, err_o (sticky timeout), blk_cnt_o.
// Build option: AES1_STREAM_BLKCNT_EN enables the completed-block counter.
module aes1_stream_ctrl
  import aes1_stream_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               encdec_i,
  input  logic [WORD_W-1:0]  s_data_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  output logic [BLOCK_W-1:0] block_o,
  output logic               encdec_o,
  output logic               next_o,
  input  logic               core_ready_i,
  input  logic               core_valid_i,
  input  logic [BLOCK_W-1:0] core_result_i,
  output logic [WORD_W-1:0]  m_data_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic               busy_o,
  output logic               err_o,
  output logic [31:0]        blk_cnt_o
);

  localparam int unsigned TW =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] WAIT_LAST =
    TW'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [1:0]         wcnt_q;
  logic [1:0]         rcnt_q;
  logic [TW-1:0]      wait_q;
  logic [BLOCK_W-1:0] block_q;
  logic [BLOCK_W-1:0] result_q;
  logic               enc_q;
  logic               err_q;

  logic accept_ok;
  logic s_fire;
  logic m_fire;
  logic capture;
  logic tmo;
  logic fill_last;
  logic drain_last;

  assign accept_ok = (state_q == S_IDLE)
                  || (state_q == S_FILL);

  // flush_i gates every event so an abort wins over
  // any handshake or core response in the same cycle.
  assign s_fire = s_valid_i && accept_ok && !flush_i;

  assign m_fire = (state_q == S_DRAIN)
               && m_ready_i && !flush_i;

  // wait_q == 0 is the guard cycle: the core may still
  // show the previous block's result there.
  assign capture = (state_q == S_WAIT)
                && (wait_q != '0)
                && core_ready_i
                && core_valid_i
                && !flush_i;

  assign tmo = (state_q == S_WAIT)
            && !capture
            && (wait_q == WAIT_LAST)
            && !flush_i;

  assign fill_last  = s_fire && (wcnt_q == 2'd3);
  assign drain_last = m_fire && (rcnt_q == 2'd3);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (s_fire) state_d = S_FILL;
      end
      S_FILL: begin
        if (fill_last) state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (capture)  state_d = S_DRAIN;
        else if (tmo) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (drain_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      wait_q   <= '0;
      block_q  <= '0;
      result_q <= '0;
      enc_q    <= 1'b0;
    end else if (flush_i) begin
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      wait_q   <= '0;
      block_q  <= '0;
      result_q <= '0;
    end else begin
      if (s_fire) begin
        block_q[wcnt_q*WORD_W +: WORD_W] <= s_data_i;
        wcnt_q <= wcnt_q + 2'd1;
        if (wcnt_q == 2'd0) enc_q <= encdec_i;
      end
      if (state_q == S_START) begin
        wait_q <= '0;
      end else if (state_q == S_WAIT) begin
        wait_q <= wait_q + 1'b1;
      end
      if (capture) begin
        result_q <= core_result_i;
        rcnt_q   <= '0;
      end
      if (m_fire) begin
        rcnt_q <= rcnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (tmo) begin
      err_q <= 1'b1;
    end
  end

`ifdef AES1_STREAM_BLKCNT_EN
  logic [31:0] blk_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk_q <= '0;
    end else if (drain_last) begin
      blk_q <= blk_q + 32'd1;
    end
  end

  assign blk_cnt_o = blk_q;
`else
  assign blk_cnt_o = '0;
`endif

  assign s_ready_o = accept_ok;
  assign next_o    = (state_q == S_START) && !flush_i;
  assign m_valid_o = (state_q == S_DRAIN);
  assign m_data_o  = result_q[rcnt_q*WORD_W +: WORD_W];
  assign busy_o    = (state_q != S_IDLE);
  assign err_o     = err_q;
  assign encdec_o  = enc_q;
  assign block_o   = block_q;

endmodule

// File: tb/tb_aes1_stream_ctrl.sv
// Self-checking bench for aes1_stream_ctrl with a stand-in AES core.
// Table vectors, hand sequences and a randomized scoreboard run.
module tb_aes1_stream_ctrl;
  import aes1_stream_pkg::*;

  localparam logic [127:0] PT =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic [3:0][31:0] w;
    logic             enc;
    int               lat;
    int               stall;
    logic [127:0]     res;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         encdec;
  logic [127:0] block_o;
  logic         encdec_o;
  logic         next_o;
  logic         core_ready;
  logic         core_valid;
  logic [127:0] core_result;
  logic         busy;
  logic         err;
  logic [31:0]  blk_cnt;

  aes1_stream_if in_if ();
  aes1_stream_if out_if ();

  int checks = 0;
  int errors = 0;
  int exp_blk = 0;
  int core_lat = 3;
  bit core_stall = 1'b0;

  logic [31:0] part[$];
  logic        part_enc;
  logic [31:0] expq[$];
  int          out_n = 0;

  vec_t tbl[4];

  always #5 clk = ~clk;

  aes1_stream_ctrl #(.TIMEOUT(8)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .encdec_i      (encdec),
    .s_data_i      (in_if.data),
    .s_valid_i     (in_if.valid),
    .s_ready_o     (in_if.ready),
    .block_o       (block_o),
    .encdec_o      (encdec_o),
    .next_o        (next_o),
    .core_ready_i  (core_ready),
    .core_valid_i  (core_valid),
    .core_result_i (core_result),
    .m_data_o      (out_if.data),
    .m_valid_o     (out_if.valid),
    .m_ready_i     (out_if.ready),
    .busy_o        (busy),
    .err_o         (err),
    .blk_cnt_o     (blk_cnt)
  );

  // Stand-in core: real AES answer for the FIPS-197 vector,
  // a simple reversible scramble for everything else.
  function automatic logic [127:0] core_fn(
    input logic [127:0] b, input logic m);
    logic [31:0] k;
    if (m && b == PT) return CT;
    k = m ? 32'hA5A55A5A : 32'h0FF0F00F;
    return {b[95:0], b[127:96]} ^ {k, k, k, k};
  endfunction

  function automatic logic [31:0] blk_exp(input int n);
`ifdef AES1_STREAM_BLKCNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'd0;
`endif
  endfunction

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  initial begin : core_model
    bit           seen;
    logic [127:0] b;
    logic         m;
    logic [127:0] res;
    int           cnt;
    cnt = 0;
    res = '0;
    core_ready = 1'b1;
    core_valid = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      seen = next_o;
      b = block_o;
      m = encdec_o;
      @(posedge clk);
      #1;
      if (seen) begin
        core_ready = 1'b0;
        core_valid = 1'b0;
        cnt = core_lat;
        res = core_fn(b, m);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_ready = !core_stall;
          core_valid = 1'b1;
          core_result = res;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic send_block(input logic [3:0][31:0] w,
                            input logic enc);
    for (int k = 0; k < 4; k++) begin
      in_if.data = w[k];
      in_if.valid = 1'b1;
      encdec = (k == 0) ? enc : !enc;
      @(negedge clk);
      chk("s_ready_fill", in_if.ready, 1'b1);
      @(posedge clk);
      #1;
    end
    in_if.valid = 1'b0;
    @(negedge clk);
    chk("next_pulse", next_o, 1'b1);
    chk("block_o", block_o, w);
    chk("encdec_o", encdec_o, enc);
    chk("s_ready_start", in_if.ready, 1'b0);
    chk("busy_start", busy, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("next_one_cycle", next_o, 1'b0);
  endtask

  task automatic drain_block(input logic [127:0] res,
                             input int lat,
                             input int stall);
    int k;
    bit nx;
    k = 1;
    nx = 1'b0;
    while (!out_if.valid && k < 30) begin
      cyc();
      k++;
      if (next_o) nx = 1'b1;
    end
    chk("valid_latency", k, lat + 2);
    chk("no_extra_next", nx, 1'b0);
    chk("m_data_first", out_if.data, res[31:0]);
    for (int s = 0; s < stall; s++) begin
      cyc();
      chk("stall_valid", out_if.valid, 1'b1);
      chk("stall_data", out_if.data, res[31:0]);
    end
    @(posedge clk);
    #1;
    out_if.ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("drain_valid", out_if.valid, 1'b1);
      chk("drain_data", out_if.data, res[32*j +: 32]);
      @(posedge clk);
      #1;
    end
    out_if.ready = 1'b0;
    exp_blk++;
    @(negedge clk);
    chk("idle_after", busy, 1'b0);
    chk("valid_after", out_if.valid, 1'b0);
    chk("blk_cnt", blk_cnt, blk_exp(exp_blk));
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    core_lat = v.lat;
    send_block(v.w, v.enc);
    drain_block(v.res, v.lat, v.stall);
  endtask

  task automatic rand_step(input bit rnd);
    logic [127:0] r;
    if (rnd) begin
      in_if.valid = ($urandom_range(0, 3) != 0);
      in_if.data = $urandom;
      encdec = 1'($urandom);
      out_if.ready = ($urandom_range(0, 2) != 0);
      core_lat = $urandom_range(1, 6);
    end else begin
      in_if.valid = 1'b0;
      out_if.ready = 1'b1;
    end
    @(negedge clk);
    chk("rand_blk_cnt", blk_cnt, blk_exp(exp_blk));
    if (out_if.valid && out_if.ready) begin
      if (expq.size() == 0) begin
        chk("rand_unexpected", out_if.valid, 1'b0);
      end else begin
        chk("rand_out", out_if.data, expq.pop_front());
        out_n++;
        if (out_n % 4 == 0) exp_blk++;
      end
    end
    if (in_if.valid && in_if.ready) begin
      if (part.size() == 0) part_enc = encdec;
      part.push_back(in_if.data);
      if (part.size() == 4) begin
        r = core_fn({part[3], part[2], part[1], part[0]},
                    part_enc);
        for (int j = 0; j < 4; j++)
          expq.push_back(r[32*j +: 32]);
        part.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  k;
    bit  nx;
    bit  mv;

    tbl[0].w = '{32'h00112233, 32'h44556677,
                 32'h8899aabb, 32'hccddeeff};
    tbl[0].enc = 1'b1;
    tbl[0].lat = 3;
    tbl[0].stall = 0;
    tbl[0].res = CT;

    tbl[1] = tbl[0];
    tbl[1].lat = 1;
    tbl[1].stall = 5;

    tbl[2].w = '{32'hcafef00d, 32'hdeadbeef,
                 32'h89abcdef, 32'h01234567};
    tbl[2].enc = 1'b0;
    tbl[2].lat = 6;
    tbl[2].stall = 2;
    tbl[2].res = core_fn(tbl[2].w, 1'b0);

    tbl[3].w = '{32'h0badc0de, 32'h13579bdf,
                 32'h2468ace0, 32'hffffffff};
    tbl[3].enc = 1'b1;
    tbl[3].lat = 2;
    tbl[3].stall = 1;
    tbl[3].res = core_fn(tbl[3].w, 1'b1);

    rst_n = 1'b0;
    flush = 1'b0;
    encdec = 1'b0;
    in_if.data = '0;
    in_if.valid = 1'b0;
    out_if.ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", in_if.ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_next", next_o, 1'b0);
    chk("rst_m_valid", out_if.valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_block", block_o, 128'd0);
    chk("rst_encdec", encdec_o, 1'b0);
    chk("rst_m_data", out_if.data, 32'd0);
    chk("rst_blk_cnt", blk_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // flush after two accepted words, third word dropped
    for (int i = 0; i < 2; i++) begin
      in_if.data = tbl[3].w[i];
      in_if.valid = 1'b1;
      encdec = 1'b1;
      @(posedge clk);
      #1;
    end
    in_if.data = tbl[3].w[2];
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_before", busy, 1'b1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_if.valid = 1'b0;
    @(negedge clk);
    chk("flush_idle", busy, 1'b0);
    nx = next_o;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (next_o) nx = 1'b1;
    end
    chk("flush_no_next", nx, 1'b0);
    @(posedge clk);
    #1;
    run_vec(tbl[0]);

    // randomized traffic against the scoreboard
    for (int c = 0; c < 600; c++) rand_step(1'b1);
    for (int c = 0; c < 40; c++) rand_step(1'b0);
    chk("rand_drained", expq.size(), 0);
    chk("rand_err", err, 1'b0);
    out_if.ready = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    part.delete();
    @(negedge clk);
    chk("rand_idle", busy, 1'b0);
    @(posedge clk);
    #1;

    // stalled core: timeout after 8 WAIT cycles
    core_stall = 1'b1;
    core_lat = 2;
    send_block(tbl[0].w, 1'b1);
    k = 1;
    mv = 1'b0;
    while (!err && k < 20) begin
      cyc();
      k++;
      if (out_if.valid) mv = 1'b1;
    end
    chk("timeout_cycles", k, 9);
    chk("timeout_err", err, 1'b1);
    chk("timeout_idle", busy, 1'b0);
    chk("timeout_no_out", mv, 1'b0);
    chk("timeout_s_ready", in_if.ready, 1'b1);
    cyc();
    chk("err_sticky", err, 1'b1);
    @(posedge clk);
    #1;
    core_stall = 1'b0;

    // reset in WAIT abandons the block
    core_lat = 4;
    send_block(tbl[2].w, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wrst_busy", busy, 1'b0);
    chk("wrst_s_ready", in_if.ready, 1'b1);
    chk("wrst_next", next_o, 1'b0);
    chk("wrst_m_valid", out_if.valid, 1'b0);
    chk("wrst_err", err, 1'b0);
    chk("wrst_block", block_o, 128'd0);
    chk("wrst_encdec", encdec_o, 1'b0);
    chk("wrst_m_data", out_if.data, 32'd0);
    chk("wrst_blk_cnt", blk_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_blk = 0;
    nx = 1'b0;
    mv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (next_o) nx = 1'b1;
      if (out_if.valid) mv = 1'b1;
    end
    chk("wrst_no_next", nx, 1'b0);
    chk("wrst_no_out", mv, 1'b0);
    chk("wrst_blk_after", blk_cnt, 32'd0);
    @(posedge clk);
    #1;
    run_vec(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
